rijndael_inv_subbytes_seq: RTL
==============================

RIJNDAEL_INV_SUBBYTES_SEQ -- requirements
Module: rijndael_inv_subbytes_seq

Interface
REQ-001 SHALL have parameter NB, default 4, state width in 32-bit columns (legal 4, 6, 8).
REQ-002 SHALL have parameter NSBOX, default 4, inverse S-boxes evaluated per cycle (legal 1, 2, 4, 8; must divide 4*NB).
REQ-003 SHALL derive localparam STATESIZE = 32*NB and NCHUNK = 4*NB/NSBOX; neither overridable.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port valid_i  input  1  input block valid.
REQ-007 SHALL have port ready_o  output  1  block ready to accept input.
REQ-008 SHALL have port state_i  input  STATESIZE  ciphertext-side state; byte k = state_i[8k+7:8k].
REQ-009 SHALL have port valid_o  output  1  result valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts result.
REQ-011 SHALL have port state_o  output  STATESIZE  InvSubBytes(state_i), same byte mapping.

Function
REQ-012 SHALL apply FIPS-197 inverse S-box independently to every byte; no row/column mixing.
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; ready_o = 1 only in IDLE, valid_o = 1 only in DONE.
REQ-014 IDLE: on valid_i && ready_o, SHALL load state_i into internal register, clear chunk counter to 0, go BUSY; otherwise stay.
REQ-015 BUSY: each cycle SHALL replace bytes [cnt*NSBOX, cnt*NSBOX+NSBOX-1] with their inverse S-box values and increment cnt.
REQ-016 BUSY: on the cycle cnt = NCHUNK-1 the last chunk SHALL be written and FSM go DONE; cnt wraps to 0.
REQ-017 Latency: valid_o SHALL rise exactly NCHUNK cycles after the accepting edge (4 for defaults; 16 for NB=4, NSBOX=1).
REQ-018 DONE: state_o and valid_o SHALL hold stable until ready_i is sampled high; then go IDLE on that edge.
REQ-019 SHALL not accept a new block in the cycle the result is consumed; max throughput one block per NCHUNK+2 cycles.
REQ-020 valid_i while ready_o = 0 SHALL be ignored; state_i changes during BUSY/DONE SHALL not affect the result.
REQ-021 state_o SHALL be driven directly from the internal register (no combinational path from state_i).
REQ-022 Bytes not yet processed in BUSY SHALL remain unmodified; each byte transformed exactly once per block.

Reset
REQ-023 rst_ni low SHALL asynchronously force FSM to IDLE, cnt = 0, internal register = 0, valid_o = 0, ready_o = 1, state_o = 0.
REQ-024 Reset asserted in BUSY or DONE SHALL abort the block; no result emitted after release.
REQ-025 Deassertion SHALL be synchronized externally; first accept possible on first rising edge after rst_ni high.

Configuration
REQ-026 Macro RIJNDAEL_INV_SUBBYTES_CLEAR_EN: when defined, internal register SHALL be zeroed on the edge the result is consumed (DONE && ready_i), so state_o = 0 in IDLE.
REQ-027 Without RIJNDAEL_INV_SUBBYTES_CLEAR_EN, the register SHALL retain the last result in IDLE; state_o shows it until the next accept.
REQ-028 The macro SHALL not change latency, handshake timing, or ports.

Verification
REQ-029 Defaults, all bytes 0x63, ready_i = 1 -> valid_o high 4 cycles after accept, state_o = all 0x00, ready_o high one cycle later.
REQ-030 Bytes 0..3 = 0x7C, 0x00, 0xFE, 0xED repeating -> output bytes 0x01, 0x52, 0x0C, 0x53 repeating.
REQ-031 NB=8, NSBOX=1, random state -> valid_o after 32 cycles, equals byte-wise inverse S-box reference; cross-check Sbox(InvSbox(x)) = x for all 256 x.
REQ-032 Hold ready_i = 0 for 10 cycles in DONE while toggling valid_i/state_i -> state_o stable, ready_o = 0, single result consumed.
REQ-033 Assert rst_ni low at cycle 2 of BUSY -> valid_o = 0, state_o = 0, ready_o = 1 immediately; no stale result after release.
REQ-034 With and without RIJNDAEL_INV_SUBBYTES_CLEAR_EN, consume result 0x00.. -> state_o in IDLE = 0 vs. retained last result.

Source files
------------

// File: rtl/rijndael_inv_subbytes_seq.sv
// Sequential Rijndael InvSubBytes: NSBOX inverse S-box lookups per cycle over an NB-column state.
// Optional macro RIJNDAEL_INV_SUBBYTES_CLEAR_EN zeroes the state register when the result is consumed.

module rijndael_inv_sbox (
   input  logic [7:0] x_i,
   output logic [7:0] y_o
);
   // Row-major FIPS-197 inverse S-box; entry 0x00 sits in the most significant byte.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign y_o = INV_SBOX[{~x_i, 3'b000} +: 8];
endmodule

module rijndael_inv_subbytes_seq #(
   parameter int NB    = 4,
   parameter int NSBOX = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [32*NB-1:0]    state_i,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [32*NB-1:0]    state_o
);
   localparam int STATESIZE = 32*NB;
   localparam int NCHUNK    = 4*NB/NSBOX;
   localparam int CW        = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK-1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]                          st_q, st_d;
   logic [CW-1:0]                       cnt_q, cnt_d;
   logic [NCHUNK-1:0][NSBOX-1:0][7:0]   data_q, data_d;
   logic [NSBOX-1:0][7:0]               chunk_in, chunk_out;

   // Only the active chunk is routed through the S-box lanes.
   assign chunk_in = data_q[cnt_q];

   for (genvar g = 0; g < NSBOX; g++) begin : g_lane
      rijndael_inv_sbox u_sbox (
         .x_i (chunk_in[g]),
         .y_o (chunk_out[g])
      );
   end

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      case (st_q)
         IDLE: begin
            if (valid_i) begin
               data_d = state_i;
               cnt_d  = '0;
               st_d   = BUSY;
            end
         end
         BUSY: begin
            data_d[cnt_q] = chunk_out;
            if (cnt_q == LAST) begin
               cnt_d = '0;
               st_d  = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (ready_i) begin
               st_d = IDLE;
`ifdef RIJNDAEL_INV_SUBBYTES_CLEAR_EN
               data_d = '0;
`else
               data_d = data_q;
`endif
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q   <= IDLE;
         cnt_q  <= '0;
         data_q <= '0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
      end
   end

   assign ready_o = (st_q == IDLE);
   assign valid_o = (st_q == DONE);
   assign state_o = STATESIZE'(data_q);
endmodule
